bus_sequencer: RTL and testbench

Two-state fetch/execute sequencer for the nic8 datapath. It fetches one instruction byte per instruction from program memory and, in the following cycle, selects exactly one bus source and strobes exactly one destination. It sits directly upstream of the register file: it drives the register file's `triggerA/B/X/Q` and `assertBarA/B/X` lines, plus the ALU, immediate and RAM enables that share `dbus`.

---
 rtl/bus_sequencer.sv | 92 +++++++++
 tb/tb_bus_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: nic8 fetch/execute sequencer driving one bus source and one load strobe per instruction.
// Optional feature: define BUS_SEQ_CONDJUMP_EN to make destination 6 a carry-conditional PC load.
module bus_sequencer (
   input  logic       clk,
   input  logic       resetBar,
   input  logic [7:0] pdata,
   input  logic [7:0] dbus,
   input  logic       aluCarry,
   output logic [7:0] pc,
   output logic [7:0] ir,
   output logic       halted,
   output logic       assertBarA,
   output logic       assertBarB,
   output logic       assertBarX,
   output logic       assertBarAlu,
   output logic       assertBarImm,
   output logic       assertBarRam,
   output logic       triggerA,
   output logic       triggerB,
   output logic       triggerX,
   output logic       triggerQ,
   output logic       triggerRam
);
   typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;
   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d, ir_q, ir_d;
   logic [5:0] src_q, src_d;
   logic [4:0] dst_q, dst_d;
   logic       jmp_q, jmp_d, cjmp_q, cjmp_d;
   logic [2:0] f_src, f_dst;
   logic       f_nop, f_kill, exec, take, cond_ok;
`ifdef BUS_SEQ_CONDJUMP_EN
   assign cond_ok = aluCarry;
`else
   logic unused_carry;
   assign unused_carry = aluCarry;
   assign cond_ok      = 1'b0;
`endif
   assign f_src  = pdata[6:4];
   assign f_dst  = pdata[2:0];
   assign f_nop  = (f_src > 3'd5) | (f_src == 3'd5 & f_dst == 3'd4) | (f_dst == 3'd7);
   assign f_kill = pdata[7] | f_nop;
   assign exec   = state_q == EXEC;
   assign take   = jmp_q | (cjmp_q & cond_ok);
   // next state: FETCH latches the instruction and pre-decodes it into one-hot registers, EXEC updates pc
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      src_d   = src_q;
      dst_d   = dst_q;
      jmp_d   = jmp_q;
      cjmp_d  = cjmp_q;
      if (state_q == FETCH) begin
         state_d = pdata[7] ? HALT : EXEC;
         ir_d    = pdata;
         pc_d    = pc_q + 8'd1;
         src_d   = f_kill ? 6'd0 : 6'd1 << f_src;
         dst_d   = (f_kill | f_dst > 3'd4) ? 5'd0 : 5'd1 << f_dst;
         jmp_d   = !f_kill & f_dst == 3'd5;
         cjmp_d  = !f_kill & f_dst == 3'd6;
      end else if (state_q == EXEC) begin
         state_d = FETCH;
         pc_d    = take ? dbus : src_q[4] ? pc_q + 8'd1 : pc_q;
      end
   end
   // state and datapath registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge resetBar) begin
      if (!resetBar) begin
         state_q <= FETCH;
         pc_q    <= 8'd0;
         ir_q    <= 8'd0;
         src_q   <= 6'd0;
         dst_q   <= 5'd0;
         jmp_q   <= 1'b0;
         cjmp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         jmp_q   <= jmp_d;
         cjmp_q  <= cjmp_d;
      end
   end
   assign pc     = pc_q;
   assign ir     = ir_q;
   assign halted = state_q == HALT;
   assign {assertBarRam, assertBarImm, assertBarAlu, assertBarX, assertBarB, assertBarA} = ~(src_q & {6{exec}});
   assign {triggerRam, triggerQ, triggerX, triggerB, triggerA} = dst_q & {5{exec & ~clk}};
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: directed table, corner sequences and random programs checked against an instruction-level model.
module tb_bus_sequencer;
   logic       clk = 1'b0, resetBar = 1'b0, aluCarry = 1'b0;
   logic [7:0] pdata, dbus, pc, ir;
   logic       halted;
   logic       assertBarA, assertBarB, assertBarX, assertBarAlu, assertBarImm, assertBarRam;
   logic       triggerA, triggerB, triggerX, triggerQ, triggerRam;
   logic [7:0] mem [256];
   logic [7:0] ra = 8'h11, rb = 8'h22, rx = 8'h33, rq = 8'h44, rram = 8'h55;
   logic [7:0] m_a = 8'h11, m_b = 8'h22, m_x = 8'h33, m_q = 8'h44, m_ram = 8'h55;
   logic [7:0] m_pc = 8'd0;
   logic       m_halt = 1'b0;
   int         total = 0, bad = 0;
   logic [5:0] abar;
   logic [4:0] trg;

   bus_sequencer dut (
      .clk(clk), .resetBar(resetBar), .pdata(pdata), .dbus(dbus), .aluCarry(aluCarry),
      .pc(pc), .ir(ir), .halted(halted),
      .assertBarA(assertBarA), .assertBarB(assertBarB), .assertBarX(assertBarX),
      .assertBarAlu(assertBarAlu), .assertBarImm(assertBarImm), .assertBarRam(assertBarRam),
      .triggerA(triggerA), .triggerB(triggerB), .triggerX(triggerX), .triggerQ(triggerQ),
      .triggerRam(triggerRam)
   );

   always #5 clk = ~clk;

   assign pdata = mem[pc];
   assign abar  = {assertBarRam, assertBarImm, assertBarAlu, assertBarX, assertBarB, assertBarA};
   assign trg   = {triggerRam, triggerQ, triggerX, triggerB, triggerA};

   always_comb begin
      dbus = 8'h00;
      if (!assertBarA) dbus = ra;
      else if (!assertBarB) dbus = rb;
      else if (!assertBarX) dbus = rx;
      else if (!assertBarAlu) dbus = ra + rb;
      else if (!assertBarImm) dbus = pdata;
      else if (!assertBarRam) dbus = rram;
   end

   always @(posedge triggerA) ra <= dbus;
   always @(posedge triggerB) rb <= dbus;
   always @(posedge triggerX) rx <= dbus;
   always @(posedge triggerQ) rq <= dbus;
   always @(posedge triggerRam) rram <= dbus;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      resetBar = 1'b0;
      repeat (2) @(negedge clk);
      #2 resetBar = 1'b1;
      m_pc   = 8'd0;
      m_halt = 1'b0;
   endtask

   // one instruction, entered anywhere in its FETCH cycle; returns EXEC-phase observations
   task automatic step(input logic carry, output logic [5:0] ab_x, output logic [4:0] tg_x, output logic [7:0] pc_x);
      logic [7:0] b, val, npc;
      int         s, d;
      logic       nop, jump;
      logic [5:0] e_ab;
      logic [4:0] e_tg;
      aluCarry = carry;
      chk("fetch_pc", pc, m_pc);
      chk("fetch_halted", halted, 0);
      chk("fetch_abar", abar, 6'h3f);
      chk("fetch_trg", trg, 0);
      b = mem[m_pc];
      @(posedge clk); #1;
      m_pc = m_pc + 8'd1;
      chk("ir", ir, b);
      chk("exec_pc", pc, m_pc);
      ab_x = abar;
      tg_x = 5'd0;
      pc_x = pc;
      if (b[7]) begin
         m_halt = 1'b1;
         chk("halt_flag", halted, 1);
         chk("halt_abar", abar, 6'h3f);
         @(negedge clk); #1;
         chk("halt_trg", trg, 0);
         return;
      end
      s    = int'(b[6:4]);
      d    = int'(b[2:0]);
      nop  = s > 5 || (s == 5 && d == 4) || d == 7;
      e_ab = nop ? 6'h3f : ~(6'd1 << s);
      e_tg = (nop || d > 4) ? 5'd0 : 5'd1 << d;
      case (s)
         0: val = m_a;
         1: val = m_b;
         2: val = m_x;
         3: val = m_a + m_b;
         4: val = mem[m_pc];
         default: val = m_ram;
      endcase
`ifdef BUS_SEQ_CONDJUMP_EN
      jump = !nop && (d == 5 || (d == 6 && carry));
`else
      jump = !nop && d == 5;
`endif
      npc = jump ? val : (!nop && s == 4) ? m_pc + 8'd1 : m_pc;
      chk("exec_abar", abar, e_ab);
      chk("exec_trg_high_half", trg, 0);
      @(negedge clk); #1;
      chk("exec_trg_low_half", trg, e_tg);
      chk("exec_abar_low_half", abar, e_ab);
      tg_x = trg;
      if (e_tg[0]) m_a = val;
      if (e_tg[1]) m_b = val;
      if (e_tg[2]) m_x = val;
      if (e_tg[3]) m_q = val;
      if (e_tg[4]) m_ram = val;
      @(posedge clk); #1;
      m_pc = npc;
      pc_x = pc;
      chk("next_pc", pc, m_pc);
      chk("regs", {ra, rb, rx, rq, rram}, {m_a, m_b, m_x, m_q, m_ram});
   endtask

   typedef struct {
      logic [7:0] ins;
      logic [7:0] imm;
      logic       carry;
      logic [5:0] e_ab;
      logic [4:0] e_tg;
      logic [7:0] e_pc;
   } vec_t;

   initial begin
      vec_t       vt [13];
      logic [5:0] ab;
      logic [4:0] tg;
      logic [7:0] px;
      logic [7:0] r;
      for (int i = 0; i < 256; i++) mem[i] = 8'h07;
`ifdef BUS_SEQ_CONDJUMP_EN
      vt[0] = '{8'h16, 8'h00, 1'b1, 6'b111101, 5'b00000, 8'h22};
      vt[6] = '{8'h46, 8'h30, 1'b1, 6'b101111, 5'b00000, 8'h30};
`else
      vt[0] = '{8'h16, 8'h00, 1'b1, 6'b111101, 5'b00000, 8'h01};
      vt[6] = '{8'h46, 8'h30, 1'b1, 6'b101111, 5'b00000, 8'h02};
`endif
      vt[1]  = '{8'h40, 8'h2A, 1'b0, 6'b101111, 5'b00001, 8'h02};
      vt[2]  = '{8'h45, 8'h10, 1'b0, 6'b101111, 5'b00000, 8'h10};
      vt[3]  = '{8'h24, 8'h00, 1'b0, 6'b111011, 5'b10000, 8'h01};
      vt[4]  = '{8'h03, 8'h00, 1'b0, 6'b111110, 5'b01000, 8'h01};
      vt[5]  = '{8'h46, 8'h30, 1'b0, 6'b101111, 5'b00000, 8'h02};
      vt[7]  = '{8'h67, 8'h00, 1'b0, 6'b111111, 5'b00000, 8'h01};
      vt[8]  = '{8'h54, 8'h00, 1'b0, 6'b111111, 5'b00000, 8'h01};
      vt[9]  = '{8'h47, 8'h00, 1'b0, 6'b111111, 5'b00000, 8'h01};
      vt[10] = '{8'h31, 8'h00, 1'b0, 6'b110111, 5'b00010, 8'h01};
      vt[11] = '{8'h5A, 8'h00, 1'b0, 6'b011111, 5'b00100, 8'h01};
      vt[12] = '{8'h12, 8'h00, 1'b0, 6'b111101, 5'b00100, 8'h01};
      #1;
      chk("rst_pc", pc, 0);
      chk("rst_ir", ir, 0);
      chk("rst_halted", halted, 0);
      chk("rst_abar", abar, 6'h3f);
      chk("rst_trg", trg, 0);
      for (int i = 0; i < 13; i++) begin
         do_reset();
         mem[0] = vt[i].ins;
         mem[1] = vt[i].imm;
         step(vt[i].carry, ab, tg, px);
         chk($sformatf("vec%0d_abar", i), ab, vt[i].e_ab);
         chk($sformatf("vec%0d_trg", i), tg, vt[i].e_tg);
         chk($sformatf("vec%0d_pc", i), px, vt[i].e_pc);
      end
      do_reset();
      for (int i = 0; i < 7; i++) mem[i] = 8'h07;
      mem[7] = 8'h80;
      for (int i = 0; i < 8; i++) step(1'b0, ab, tg, px);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         chk("halt_frozen", {halted, pc, ir, abar, trg}, {1'b1, 8'h08, 8'h80, 6'h3f, 5'h00});
      end
      do_reset();
      mem[0] = 8'h41;
      mem[1] = 8'h55;
      @(posedge clk); #1;
      @(negedge clk); #1;
      chk("midexec_trgB", triggerB, 1);
      resetBar = 1'b0;
      #1;
      chk("midexec_rst", {trg, abar, pc, ir, halted}, {5'h00, 6'h3f, 8'h00, 8'h00, 1'b0});
      m_b = 8'h55;
      #1 resetBar = 1'b1;
      m_pc = 8'd0;
      m_halt = 1'b0;
      mem[0] = 8'h45;
      mem[1] = 8'hFF;
      mem[255] = 8'h07;
      step(1'b0, ab, tg, px);
      chk("wrap_jump", px, 8'hFF);
      step(1'b0, ab, tg, px);
      chk("wrap_pc", px, 8'h00);
      for (int i = 0; i < 256; i++) begin
         r = 8'($urandom);
         mem[i] = ($urandom_range(0, 19) == 0) ? (r | 8'h80) : (r & 8'h7F);
      end
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if (m_halt) do_reset();
         step(1'($urandom_range(0, 1)), ab, tg, px);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
